// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the convolution datapath.
//   - ofm_state_t / ST_* : writeback FSM state encoding (IDLE/COLLECT/DRAIN/DONE)
//   - calc_oh()          : output feature-map height/width from layer geometry
//   - calc_total()       : number of OFM words produced by one layer
// -----------------------------------------------------------------------------
package cnn_pkg;

  typedef logic [1:0] ofm_state_t;

  localparam ofm_state_t ST_IDLE    = 2'd0;
  localparam ofm_state_t ST_COLLECT = 2'd1;
  localparam ofm_state_t ST_DRAIN   = 2'd2;
  localparam ofm_state_t ST_DONE    = 2'd3;

  // Output size of a valid (unpadded here; padding is already in ifm_size) conv.
  function automatic int calc_oh(input int ifm_size, input int kernel_size, input int stride);
    return (ifm_size - kernel_size) / stride + 1;
  endfunction

  // Words per layer: one per output channel and spatial position.
  function automatic int calc_total(input int co, input int oh);
    return co * oh * oh;
  endfunction

endpackage

// File: rtl/ofm_fifo.sv
// -----------------------------------------------------------------------------
// ofm_fifo
// Synchronous FIFO, DEPTH x DATA_W, with a registered head.
//   clk1, rst_n   : clock, asynchronous active-low reset
//   i_clr         : synchronous flush (pointers, count, head)
//   i_push/i_din  : write request and data (dropped if full with no pop)
//   i_pop         : remove the current head (ignored when empty)
//   o_full        : all DEPTH entries occupied
//   o_empty_nxt   : FIFO will hold no entries after this edge
//   o_head_vld    : registered "head present" flag
//   o_head        : registered head word, stable until popped
// The head register is loaded from entries that existed before the current
// edge, so a word pushed at edge N is presented after edge N+1.
// -----------------------------------------------------------------------------
module ofm_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_full,
  output logic              o_empty_nxt,
  output logic              o_head_vld,
  output logic [DATA_W-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_head_vld;
  logic [DATA_W-1:0] r_head;

  logic              w_pop;
  logic              w_push;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_after_pop;

  // Handshake qualification; a full FIFO accepts a push only alongside a pop.
  always_comb begin
    w_pop           = i_pop && (r_count != '0);
    w_push          = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);
    w_rd_ptr_nxt    = r_rd_ptr + PTR_W'(w_pop);
    w_cnt_after_pop = r_count - CNT_W'(w_pop);
  end

  // Storage, pointers, occupancy and the registered head.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head_vld <= 1'b0;
      r_head     <= '0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head_vld <= 1'b0;
      r_head     <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
      end
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_cnt_after_pop + CNT_W'(w_push);
      // Only pre-edge entries feed the head, giving the extra cycle of latency.
      r_head_vld <= (w_cnt_after_pop != '0);
      r_head     <= (w_cnt_after_pop != '0) ? r_mem[w_rd_ptr_nxt] : '0;
    end
  end

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty_nxt = (w_cnt_after_pop == '0) && !w_push;
  assign o_head_vld  = r_head_vld;
  assign o_head      = r_head;

endmodule

// File: rtl/ofm_writer.sv
// -----------------------------------------------------------------------------
// ofm_writer
// Output feature-map writeback engine. Buffers the conv result stream in a
// small FIFO against memory backpressure, writes it to sequential OFM
// addresses (c*OH*OH + y*OH + x) and closes each start_conv/end_conv layer
// with a one-cycle ofm_done pulse plus sticky error flags.
//   clk1, rst_n          : clock, asynchronous active-low reset
//   start_conv           : arm for a new layer (honoured in IDLE only)
//   end_conv             : controller marks layer end
//   out_valid, out_data  : result stream
//   ofm_wr_ready         : memory accepts a write this cycle
//   ofm_wr_en/addr/data  : registered write request
//   ofm_done             : completion pulse (one cycle in DONE)
//   err_ovf              : sticky, a word was dropped on a full FIFO
//   err_short            : sticky, end_conv arrived before TOTAL words
// Build option: define OFM_RELU_EN to clamp negative words to zero on write.
// -----------------------------------------------------------------------------
module ofm_writer #(
  parameter int KERNEL_SIZE = 4,
  parameter int IFM_SIZE    = 9,
  parameter int STRIDE      = 2,
  parameter int CO          = 4,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start_conv,
  input  logic              end_conv,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_data,
  input  logic              ofm_wr_ready,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_wr_addr,
  output logic [DATA_W-1:0] ofm_wr_data,
  output logic              ofm_done,
  output logic              err_ovf,
  output logic              err_short
);

  import cnn_pkg::*;

  localparam int OH    = calc_oh(IFM_SIZE, KERNEL_SIZE, STRIDE);
  localparam int TOTAL = calc_total(CO, OH);
  localparam int RX_W  = $clog2(TOTAL + 1);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(CO - 1);
  localparam logic [RX_W-1:0]   RX_MAX = RX_W'(TOTAL);

  ofm_state_t        r_state;
  ofm_state_t        w_state_nxt;
  logic [RX_W-1:0]   r_rx_cnt;
  logic [RX_W-1:0]   w_rx_nxt;
  logic [ADDR_W-1:0] r_x, r_y, r_c, r_addr;
  logic [ADDR_W-1:0] w_x_nxt, w_y_nxt, w_c_nxt;
  logic              r_done;
  logic              r_err_ovf;
  logic              r_err_short;

  logic              w_start;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_drop;
  logic              w_pop;
  logic              w_full;
  logic              w_empty_nxt;
  logic              w_head_vld;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_din;

  // Clamp applied when the word enters the FIFO; identical to clamping on
  // pop because the FIFO is order-preserving and adds no transformation.
  function automatic logic [DATA_W-1:0] relu_f(input logic [DATA_W-1:0] d);
`ifdef OFM_RELU_EN
    if (d[DATA_W-1]) begin
      relu_f = '0;
    end else begin
      relu_f = d;
    end
`else
    relu_f = d;
`endif
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] c,
                                                input logic [ADDR_W-1:0] y,
                                                input logic [ADDR_W-1:0] x);
    addr_of = c * ADDR_W'(OH * OH) + y * ADDR_W'(OH) + x;
  endfunction

  // Stream acceptance and write handshake decode.
  always_comb begin
    w_start    = (r_state == ST_IDLE) && start_conv;
    w_pop      = w_head_vld && ofm_wr_ready;
    // Once TOTAL words are in, further words are dropped without a flag.
    w_push_req = (r_state == ST_COLLECT) && out_valid && (r_rx_cnt < RX_MAX);
    w_push_ok  = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
    w_rx_nxt   = r_rx_cnt + RX_W'(w_push_ok);
    w_din      = relu_f(out_data);
  end

  // Next-state logic for the layer FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_conv) begin
          w_state_nxt = ST_COLLECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if ((w_rx_nxt == RX_MAX) || end_conv) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        // Empty after this edge also means the head register goes invalid.
        if (w_empty_nxt) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next x/y/c position: x fastest, then y, then channel, wrapping at the end.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    w_c_nxt = r_c;
    if (w_start) begin
      w_x_nxt = '0;
      w_y_nxt = '0;
      w_c_nxt = '0;
    end else if (w_pop) begin
      if (r_x == X_LAST) begin
        w_x_nxt = '0;
        if (r_y == X_LAST) begin
          w_y_nxt = '0;
          if (r_c == C_LAST) begin
            w_c_nxt = '0;
          end else begin
            w_c_nxt = r_c + ADDR_W'(1);
          end
        end else begin
          w_y_nxt = r_y + ADDR_W'(1);
        end
      end else begin
        w_x_nxt = r_x + ADDR_W'(1);
      end
    end else begin
      w_x_nxt = r_x;
    end
  end

  // FSM state, completion pulse and receive counter.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
      r_rx_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_done   <= (w_state_nxt == ST_DONE);
      r_rx_cnt <= w_start ? '0 : w_rx_nxt;
    end
  end

  // Address counters; r_addr always mirrors the position of the current head.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= '0;
      r_addr <= '0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_c    <= w_c_nxt;
      r_addr <= addr_of(w_c_nxt, w_y_nxt, w_x_nxt);
    end
  end

  // Sticky error flags, cleared only by an accepted start_conv.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf   <= 1'b0;
      r_err_short <= 1'b0;
    end else if (w_start) begin
      r_err_ovf   <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      if (w_drop) begin
        r_err_ovf <= 1'b1;
      end
      if ((r_state == ST_COLLECT) && end_conv && (w_rx_nxt < RX_MAX)) begin
        r_err_short <= 1'b1;
      end
    end
  end

  ofm_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .i_clr       (w_start),
    .i_push      (w_push_ok),
    .i_pop       (w_pop),
    .i_din       (w_din),
    .o_full      (w_full),
    .o_empty_nxt (w_empty_nxt),
    .o_head_vld  (w_head_vld),
    .o_head      (w_head)
  );

  // FIFO holds entries only in COLLECT/DRAIN, so its head flag is the write request.
  assign ofm_wr_en   = w_head_vld;
  assign ofm_wr_data = w_head;
  assign ofm_wr_addr = r_addr;
  assign ofm_done    = r_done;
  assign err_ovf     = r_err_ovf;
  assign err_short   = r_err_short;

endmodule

// File: tb/tb_ofm_writer.sv
// -----------------------------------------------------------------------------
// tb_ofm_writer
// Self-checking bench for ofm_writer with default geometry (OH=3, TOTAL=36).
// Expected writes come from a list of accepted words plus the address rule
// c*OH*OH + y*OH + x derived from the write index.
// -----------------------------------------------------------------------------
module tb_ofm_writer;

  localparam int K_M      = 4;
  localparam int IFM_M    = 9;
  localparam int S_M      = 2;
  localparam int CO_M     = 4;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 12;
  localparam int DEPTH_M  = 4;
  localparam int OH_M     = (IFM_M - K_M) / S_M + 1;
  localparam int TOTAL_M  = CO_M * OH_M * OH_M;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_conv = 1'b0;
  logic              end_conv = 1'b0;
  logic              out_valid = 1'b0;
  logic [DATA_W-1:0] out_data = '0;
  logic              ofm_wr_ready = 1'b0;
  logic              ofm_wr_en;
  logic [ADDR_W-1:0] ofm_wr_addr;
  logic [DATA_W-1:0] ofm_wr_data;
  logic              ofm_done;
  logic              err_ovf;
  logic              err_short;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int wr_at_done = -1;
  logic [ADDR_W-1:0] obs_addr [$];
  logic [DATA_W-1:0] obs_data [$];
  logic [DATA_W-1:0] exp_data [$];

  ofm_writer #(
    .KERNEL_SIZE (K_M), .IFM_SIZE (IFM_M), .STRIDE (S_M), .CO (CO_M),
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .FIFO_DEPTH (DEPTH_M)
  ) dut (
    .clk1 (clk1), .rst_n (rst_n), .start_conv (start_conv), .end_conv (end_conv),
    .out_valid (out_valid), .out_data (out_data), .ofm_wr_ready (ofm_wr_ready),
    .ofm_wr_en (ofm_wr_en), .ofm_wr_addr (ofm_wr_addr), .ofm_wr_data (ofm_wr_data),
    .ofm_done (ofm_done), .err_ovf (err_ovf), .err_short (err_short)
  );

  always #5 clk1 = ~clk1;

  // Record completed writes and done pulses half a cycle before the edge.
  always @(negedge clk1) begin
    if (ofm_wr_en && ofm_wr_ready) begin
      obs_addr.push_back(ofm_wr_addr);
      obs_data.push_back(ofm_wr_data);
    end
    if (ofm_done) begin
      done_cnt++;
      wr_at_done = obs_addr.size();
    end
  end

  function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] d);
`ifdef OFM_RELU_EN
    return ($signed(d) < 0) ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [ADDR_W-1:0] model_addr(input int k);
    int c, y, x;
    c = k / (OH_M * OH_M);
    y = (k / OH_M) % OH_M;
    x = k % OH_M;
    return ADDR_W'(c * OH_M * OH_M + y * OH_M + x);
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    exp_data.delete();
    done_cnt = 0;
    wr_at_done = -1;
  endtask

  task automatic do_start();
    tick();
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
  endtask

  task automatic pulse_end();
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
  endtask

  // Bounded wait for ofm_done, then a few cycles to catch any extra pulse.
  task automatic wait_done(output bit timed_out);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      tick();
      n++;
    end
    timed_out = (done_cnt == 0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({ofm_wr_en, ofm_wr_addr, ofm_wr_data, ofm_done, err_ovf, err_short} !== '0) begin
      n_errors++;
      $display("FAIL reset_in got en=%b addr=%0d data=%h done=%b ovf=%b short=%b want all 0", ofm_wr_en, ofm_wr_addr, ofm_wr_data, ofm_done, err_ovf, err_short);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({ofm_wr_en, ofm_wr_addr, ofm_wr_data, ofm_done, err_ovf, err_short} !== '0) begin
      n_errors++;
      $display("FAIL reset_after got en=%b addr=%0d data=%h done=%b want all 0", ofm_wr_en, ofm_wr_addr, ofm_wr_data, ofm_done);
    end
  endtask

  task automatic test_full_stream();
    bit to;
    clear_obs();
    ofm_wr_ready = 1'b1;
    do_start();
    for (int i = 1; i <= TOTAL_M; i++) begin
      out_valid = 1'b1;
      out_data  = 16'(i);
      exp_data.push_back(model_word(16'(i)));
      if (i <= 3) begin
        @(negedge clk1);
        n_checks++;
        if (i < 3 && ofm_wr_en !== 1'b0) begin
          n_errors++;
          $display("FAIL latency_early cycle %0d got en=%b want 0", i, ofm_wr_en);
        end else if (i == 3 && {ofm_wr_en, ofm_wr_addr, ofm_wr_data} !== {1'b1, 12'd0, 16'd1}) begin
          n_errors++;
          $display("FAIL latency_first got en=%b addr=%0d data=%h want 1/0/0001", ofm_wr_en, ofm_wr_addr, ofm_wr_data);
        end
      end
      tick();
    end
    out_valid = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || done_cnt != 1 || wr_at_done != TOTAL_M) begin
      n_errors++;
      $display("FAIL full_done got timeout=%0d pulses=%0d writes_at_done=%0d want 0/1/%0d", to, done_cnt, wr_at_done, TOTAL_M);
    end
    n_checks++;
    if (obs_data.size() != exp_data.size()) begin
      n_errors++;
      $display("FAIL full_count got %0d want %0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== model_addr(k) || obs_data[k] !== exp_data[k]) begin
        n_errors++;
        $display("FAIL full_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", k, obs_addr[k], obs_data[k], model_addr(k), exp_data[k]);
      end
    end
    n_checks++;
    if (err_ovf !== 1'b0 || err_short !== 1'b0) begin
      n_errors++;
      $display("FAIL full_errs got ovf=%b short=%b want 0/0", err_ovf, err_short);
    end
  endtask

  task automatic test_stall();
    bit to;
    int w;
    clear_obs();
    do_start();
    ofm_wr_ready = 1'b0;
    w = 1;
    for (int c = 0; c < 10; c++) begin
      out_valid = (c == 0 || c == 3 || c == 6);
      out_data  = 16'(w);
      if (out_valid) begin
        exp_data.push_back(model_word(16'(w)));
        w++;
      end
      @(negedge clk1);
      if (ofm_wr_en) begin
        n_checks++;
        if (ofm_wr_addr !== 12'd0 || ofm_wr_data !== 16'd1) begin
          n_errors++;
          $display("FAIL stall_hold cycle %0d got addr=%0d data=%h want 0/0001", c, ofm_wr_addr, ofm_wr_data);
        end
      end
      tick();
    end
    n_checks++;
    if (ofm_wr_en !== 1'b1 || obs_data.size() != 0) begin
      n_errors++;
      $display("FAIL stall_pending got en=%b writes=%0d want 1/0", ofm_wr_en, obs_data.size());
    end
    ofm_wr_ready = 1'b1;
    for (; w <= TOTAL_M; w++) begin
      out_valid = 1'b1;
      out_data  = 16'(w);
      exp_data.push_back(model_word(16'(w)));
      tick();
    end
    out_valid = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || done_cnt != 1 || obs_data.size() != TOTAL_M) begin
      n_errors++;
      $display("FAIL stall_done got timeout=%0d pulses=%0d writes=%0d want 0/1/%0d", to, done_cnt, obs_data.size(), TOTAL_M);
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== model_addr(k) || obs_data[k] !== exp_data[k]) begin
        n_errors++;
        $display("FAIL stall_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", k, obs_addr[k], obs_data[k], model_addr(k), exp_data[k]);
      end
    end
    n_checks++;
    if (err_ovf !== 1'b0 || err_short !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_errs got ovf=%b short=%b want 0/0", err_ovf, err_short);
    end
  endtask

  // Six words into a 4-deep FIFO with no drain: exactly four are kept, so
  // 32 more words must complete the layer and a 33rd must be ignored.
  task automatic test_overflow();
    bit to;
    logic [DATA_W-1:0] d;
    clear_obs();
    ofm_wr_ready = 1'b0;
    do_start();
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      out_valid = 1'b1;
      out_data  = d;
      if (i < DEPTH_M) exp_data.push_back(model_word(d));
      tick();
    end
    out_valid = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (err_ovf !== 1'b1 || err_short !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_flag got ovf=%b short=%b want 1/0", err_ovf, err_short);
    end
    ofm_wr_ready = 1'b1;
    for (int i = 0; i < TOTAL_M - DEPTH_M + 1; i++) begin
      d = 16'($urandom);
      out_valid = 1'b1;
      out_data  = d;
      if (i < TOTAL_M - DEPTH_M) exp_data.push_back(model_word(d));
      tick();
    end
    out_valid = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || done_cnt != 1 || obs_data.size() != TOTAL_M) begin
      n_errors++;
      $display("FAIL ovf_done got timeout=%0d pulses=%0d writes=%0d want 0/1/%0d", to, done_cnt, obs_data.size(), TOTAL_M);
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== model_addr(k) || obs_data[k] !== exp_data[k]) begin
        n_errors++;
        $display("FAIL ovf_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", k, obs_addr[k], obs_data[k], model_addr(k), exp_data[k]);
      end
    end
    n_checks++;
    if (err_ovf !== 1'b1 || err_short !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_sticky got ovf=%b short=%b want 1/0", err_ovf, err_short);
    end
  endtask

  task automatic test_short();
    bit to;
    logic [DATA_W-1:0] d;
    clear_obs();
    ofm_wr_ready = 1'b1;
    do_start();
    n_checks++;
    if (err_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL start_clears_ovf got %b want 0", err_ovf);
    end
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      out_valid = 1'b1;
      out_data  = d;
      exp_data.push_back(model_word(d));
      tick();
    end
    out_valid = 1'b0;
    pulse_end();
    wait_done(to);
    n_checks++;
    if (to || done_cnt != 1 || obs_data.size() != 20 || wr_at_done != 20) begin
      n_errors++;
      $display("FAIL short_done got timeout=%0d pulses=%0d writes=%0d want 0/1/20", to, done_cnt, obs_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== model_addr(k) || obs_data[k] !== exp_data[k]) begin
        n_errors++;
        $display("FAIL short_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", k, obs_addr[k], obs_data[k], model_addr(k), exp_data[k]);
      end
    end
    n_checks++;
    if (err_short !== 1'b1 || err_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL short_flag got short=%b ovf=%b want 1/0", err_short, err_ovf);
    end
  endtask

  // Random data and random backpressure; ready is high at least every other
  // cycle while words arrive every third cycle, so nothing may be dropped.
  task automatic test_random_relu();
    bit to;
    int w;
    int c;
    logic [DATA_W-1:0] d;
    clear_obs();
    do_start();
    w = 0;
    c = 0;
    while (w < TOTAL_M) begin
      ofm_wr_ready = (c % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      out_valid = (c % 3 == 0);
      if (out_valid) begin
        d = (w == 9) ? 16'hFFF6 : 16'($urandom);
        out_data = d;
        exp_data.push_back(model_word(d));
        w++;
      end
      tick();
      c++;
    end
    out_valid = 1'b1;
    out_data  = 16'h7777;
    ofm_wr_ready = 1'b1;
    repeat (3) tick();
    out_valid = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || done_cnt != 1 || obs_data.size() != TOTAL_M) begin
      n_errors++;
      $display("FAIL rand_done got timeout=%0d pulses=%0d writes=%0d want 0/1/%0d", to, done_cnt, obs_data.size(), TOTAL_M);
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== model_addr(k) || obs_data[k] !== exp_data[k]) begin
        n_errors++;
        $display("FAIL rand_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", k, obs_addr[k], obs_data[k], model_addr(k), exp_data[k]);
      end
    end
    if (obs_data.size() > 9) begin
      n_checks++;
`ifdef OFM_RELU_EN
      if (obs_addr[9] !== 12'd9 || obs_data[9] !== 16'h0000) begin
`else
      if (obs_addr[9] !== 12'd9 || obs_data[9] !== 16'hFFF6) begin
`endif
        n_errors++;
        $display("FAIL relu_word10 got addr=%0d data=%h", obs_addr[9], obs_data[9]);
      end
    end
    n_checks++;
    if (err_ovf !== 1'b0 || err_short !== 1'b0) begin
      n_errors++;
      $display("FAIL rand_errs got ovf=%b short=%b want 0/0", err_ovf, err_short);
    end
  endtask

  task automatic test_ignored_start();
    bit to;
    clear_obs();
    ofm_wr_ready = 1'b1;
    do_start();
    for (int i = 1; i <= TOTAL_M; i++) begin
      if (i == 11) begin
        out_valid  = 1'b0;
        start_conv = 1'b1;
        tick();
        start_conv = 1'b0;
      end
      out_valid = 1'b1;
      out_data  = 16'(100 + i);
      exp_data.push_back(model_word(16'(100 + i)));
      tick();
    end
    out_valid = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || done_cnt != 1 || obs_data.size() != TOTAL_M) begin
      n_errors++;
      $display("FAIL ign_done got timeout=%0d pulses=%0d writes=%0d want 0/1/%0d", to, done_cnt, obs_data.size(), TOTAL_M);
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== model_addr(k) || obs_data[k] !== exp_data[k]) begin
        n_errors++;
        $display("FAIL ign_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", k, obs_addr[k], obs_data[k], model_addr(k), exp_data[k]);
      end
    end
  endtask

  task automatic test_reset_midlayer();
    bit to;
    int n0;
    clear_obs();
    ofm_wr_ready = 1'b1;
    do_start();
    for (int i = 1; i <= 15; i++) begin
      out_valid = 1'b1;
      out_data  = 16'(i);
      tick();
    end
    out_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n0 = obs_data.size();
    n_checks++;
    if ({ofm_wr_en, ofm_wr_addr, ofm_wr_data, ofm_done, err_ovf, err_short} !== '0) begin
      n_errors++;
      $display("FAIL midreset_out got en=%b addr=%0d data=%h want all 0", ofm_wr_en, ofm_wr_addr, ofm_wr_data);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out_valid = 1'b1;
      out_data  = 16'hBEEF;
      tick();
    end
    out_valid = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (obs_data.size() != n0 || ofm_wr_en !== 1'b0 || done_cnt != 0) begin
      n_errors++;
      $display("FAIL midreset_quiet got writes=%0d en=%b done=%0d want %0d/0/0", obs_data.size(), ofm_wr_en, done_cnt, n0);
    end
    clear_obs();
    do_start();
    for (int i = 1; i <= TOTAL_M; i++) begin
      out_valid = 1'b1;
      out_data  = 16'(200 + i);
      exp_data.push_back(model_word(16'(200 + i)));
      tick();
    end
    out_valid = 1'b0;
    wait_done(to);
    n_checks++;
    if (to || done_cnt != 1 || obs_data.size() != TOTAL_M) begin
      n_errors++;
      $display("FAIL restart_done got timeout=%0d pulses=%0d writes=%0d want 0/1/%0d", to, done_cnt, obs_data.size(), TOTAL_M);
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      n_checks++;
      if (obs_addr[k] !== model_addr(k) || obs_data[k] !== exp_data[k]) begin
        n_errors++;
        $display("FAIL restart_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", k, obs_addr[k], obs_data[k], model_addr(k), exp_data[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_stream();
    test_stall();
    test_overflow();
    test_short();
    test_random_relu();
    test_ignored_start();
    test_reset_midlayer();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ofm_writer.md
# ofm_writer

Output feature-map writeback engine for the convolution datapath. Consumes the `out_valid`/data stream produced by the conv controller and PE array, buffers it in a small FIFO against memory backpressure, and generates sequential OFM addresses (channel, row, column). It also closes the `start_conv` → `end_conv` transaction with a completion pulse and sticky error flags.

## Interface
- `KERNEL_SIZE`, 4, kernel width/height
- `IFM_SIZE`, 9, padded input width/height
- `STRIDE`, 2, convolution stride
- `CO`, 4, number of output channels (filters)
- `DATA_W`, 16, signed output word width
- `ADDR_W`, 12, OFM address width; must satisfy 2^ADDR_W ≥ TOTAL
- `FIFO_DEPTH`, 4, buffer entries; power of two, ≥ 2
- Derived: OH = (IFM_SIZE−KERNEL_SIZE)/STRIDE + 1 (integer division); TOTAL = CO·OH·OH. With the defaults, OH = 3 and TOTAL = 36.
- `clk1` in 1: system clock; all state is on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start_conv` in 1: one-cycle pulse that arms the block for a new layer
- `end_conv` in 1: one-cycle pulse from the controller marking layer end
- `out_valid` in 1: `out_data` is valid this cycle
- `out_data` in DATA_W: signed convolution result
- `ofm_wr_ready` in 1: memory accepts a write this cycle
- `ofm_wr_en` out 1: write request
- `ofm_wr_addr` out ADDR_W: c·OH·OH + y·OH + x
- `ofm_wr_data` out DATA_W: word to write
- `ofm_done` out 1: one-cycle completion pulse
- `err_ovf` out 1: sticky flag; a word was dropped because the FIFO was full
- `err_short` out 1: sticky flag; `end_conv` arrived before TOTAL words were received

## Operation
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE → COLLECT on `start_conv`. This clears the rx count, x/y/c counters, FIFO, `err_ovf` and `err_short`.
  - COLLECT → DRAIN when the rx count reaches TOTAL, or when `end_conv` is seen.
  - DRAIN → DONE when the FIFO is empty and no write is in flight.
  - DONE → IDLE unconditionally after one cycle.
- Push rules:
  - In COLLECT, `out_valid` pushes `out_data`.
  - If the FIFO is full, the push succeeds only when a pop occurs in the same cycle; otherwise the word is dropped and `err_ovf` is set.
  - Pushes in IDLE, DRAIN or DONE are ignored and do not count.
- Rx count increments on each accepted push and saturates at TOTAL. Words arriving after TOTAL are dropped silently.
- `end_conv` while rx count < TOTAL in COLLECT sets `err_short`; the FSM still drains.
- Write rules:
  - `ofm_wr_en` = FIFO non-empty while in COLLECT or DRAIN.
  - A write completes when `ofm_wr_en` and `ofm_wr_ready` are both high; this pops the FIFO.
  - `ofm_wr_data`/`ofm_wr_addr` hold steady while `ofm_wr_en` is high and `ofm_wr_ready` is low.
- Address counters advance on each completed write: x 0..OH−1, then y, then c 0..CO−1. They wrap to 0 after the last entry.
- Address arithmetic is computed in ADDR_W bits, unsigned.
- `start_conv` outside IDLE is ignored.

## Timing
- Reset values: `ofm_wr_en`=0, `ofm_wr_addr`=0, `ofm_wr_data`=0, `ofm_done`=0, `err_ovf`=0, `err_short`=0. FSM is in IDLE and the FIFO is empty.
- Reset mid-layer aborts immediately; no further writes occur.
- Latency: `out_valid` sampled at edge N gives `ofm_wr_en` high after edge N+1, from a registered FIFO head. Minimum throughput is 1 word/cycle with `ofm_wr_ready` held high.
- `ofm_done` is high for exactly the one cycle the FSM is in DONE, i.e. one cycle after the last pop.
- Error flags hold until the next accepted `start_conv` or reset.

## Configuration
- `OFM_RELU_EN`:
  - Defined: data popped from the FIFO with sign bit 1 is written as 0 (ReLU at writeback). This adds no latency.
  - Undefined: data passes through unchanged.

## Structure
- Shared package `cnn_pkg` holds:
  - FSM state typedef (IDLE/COLLECT/DRAIN/DONE)
  - functions computing OH and TOTAL from the parameters
- Sub-module `ofm_fifo`: synchronous FIFO, FIFO_DEPTH × DATA_W, with push/pop/full/empty, registered head, and simultaneous push+pop allowed when full.

## Test plan
- Defaults, `ofm_wr_ready`=1, 36 `out_valid` words 1..36 after `start_conv` → 36 writes to addresses 0..35 with data 1..36, then `ofm_done` pulses once, no errors.
- `ofm_wr_ready` low for 10 cycles while 3 words arrive → writes stall with addr/data stable, then resume in order; no `err_ovf`.
- `ofm_wr_ready`=0 and 6 back-to-back words with FIFO_DEPTH=4 → 4 accepted, `err_ovf`=1, rx count=4.
- `end_conv` after 20 words → `err_short`=1, 20 writes (addr 0..19), `ofm_done` pulses.
- Word 10 = 0xFFF6 (−10): with `OFM_RELU_EN` written as 0x0000; without it written as 0xFFF6 at address 9.
- Assert `rst_n` low after 15 words, then release → all outputs 0, IDLE; a new `start_conv` restarts from address 0.
